// File: rtl/phantom_clock_gate_if.sv
// Bus-side signals of the phantom timekeeper: qualified ROM accesses in, gated select and D0 drive out.
interface phantom_clock_gate_if;
    logic ACC_STB;
    logic RAMROMCS;
    logic A0;
    logic A2;
    logic TICK;
    logic RAMROMCSgb;
    logic CLKDOE;
    logic CLKD0;
    logic XFER;

    modport master (
        output ACC_STB, RAMROMCS, A0, A2, TICK,
        input  RAMROMCSgb, CLKDOE, CLKD0, XFER
    );

    modport slave (
        input  ACC_STB, RAMROMCS, A0, A2, TICK,
        output RAMROMCSgb, CLKDOE, CLKD0, XFER
    );
endinterface

// File: rtl/phantom_clock_gate.sv
// DS1215-style phantom clock: unlocks on a 64-bit ROM access pattern, then serves/accepts 64 BCD time bits.
// Optional feature macro: CENTI_EN (100 Hz TICK with a live centisecond field).
module phantom_clock_gate #(
    parameter logic [63:0] PATTERN    = 64'h5CA3_3AC5_5CA3_3AC5,
    parameter logic [63:0] RESET_TIME = 64'h0001_0101_0000_0000
) (
    input  logic                i_c7m,
    input  logic                i_res,
    phantom_clock_gate_if.slave bus
);

    typedef enum logic {ST_MATCH, ST_XFER} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_RD, DIR_WR} dir_t;

    state_t      r_state;
    dir_t        r_dir;
    logic [5:0]  r_bitcnt;
    logic [63:0] r_shift;
    logic [63:0] r_time;

    // Values at or above the field limit are treated as the limit, so they roll to the minimum.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] lim,
                                            input logic [7:0] min_v);
        logic [7:0] r;
        if (v >= lim)
            r = min_v;
        else if (v[3:0] >= 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic        w_qual;
    logic        w_pat_hit;
    logic        w_pat_first;
    logic        w_last;
    logic        w_dir_clash;
    dir_t        w_dir_now;
    logic [63:0] w_shift_wr;
    logic [63:0] w_commit;
    logic [63:0] w_time_inc;
    logic [7:0]  w_cc_next;
    logic        w_c_ss;
    logic        w_c_mm;
    logic        w_c_hh;
    logic        w_c_day;

    assign w_qual      = bus.ACC_STB & bus.RAMROMCS;
    assign w_pat_hit   = (bus.A0 == PATTERN[r_bitcnt]);
    assign w_pat_first = (bus.A0 == PATTERN[0]);
    assign w_last      = (r_bitcnt == 6'd63);
    assign w_dir_now   = bus.A2 ? DIR_RD : DIR_WR;
    assign w_dir_clash = (r_dir != DIR_NONE) && (r_dir != w_dir_now);
    assign w_shift_wr  = {bus.A0, r_shift[63:1]};

`ifdef CENTI_EN
    assign w_c_ss    = (r_time[7:0] >= 8'h99);
    assign w_cc_next = bcd_step(r_time[7:0], 8'h99, 8'h00);
    assign w_commit  = w_shift_wr;
`else
    assign w_c_ss    = 1'b1;
    assign w_cc_next = r_time[7:0];
    assign w_commit  = {w_shift_wr[63:8], 8'h00};
`endif

    assign w_c_mm  = w_c_ss & (r_time[15:8]  >= 8'h59);
    assign w_c_hh  = w_c_mm & (r_time[23:16] >= 8'h59);
    assign w_c_day = w_c_hh & (r_time[31:24] >= 8'h23);

    assign w_time_inc = {
        r_time[63:40],
        w_c_day ? bcd_step(r_time[39:32], 8'h07, 8'h01) : r_time[39:32],
        w_c_hh  ? bcd_step(r_time[31:24], 8'h23, 8'h00) : r_time[31:24],
        w_c_mm  ? bcd_step(r_time[23:16], 8'h59, 8'h00) : r_time[23:16],
        w_c_ss  ? bcd_step(r_time[15:8],  8'h59, 8'h00) : r_time[15:8],
        w_cc_next
    };

    always_ff @(posedge i_c7m) begin
        if (i_res) begin
            r_state  <= ST_MATCH;
            r_dir    <= DIR_NONE;
            r_bitcnt <= 6'd0;
            r_shift  <= 64'd0;
            r_time   <= RESET_TIME;
        end else begin
            // NOTE: non-blocking assignments resolve last-wins, so a write commit below overrides the tick.
            if (bus.TICK)
                r_time <= w_time_inc;

            if (w_qual) begin
                case (r_state)
                    ST_MATCH: begin
                        if (bus.A2) begin
                            r_bitcnt <= 6'd0;
                        end else if (w_pat_hit) begin
                            if (w_last) begin
                                r_state  <= ST_XFER;
                                r_bitcnt <= 6'd0;
                                r_dir    <= DIR_NONE;
                                r_shift  <= r_time;
                            end else begin
                                r_bitcnt <= r_bitcnt + 6'd1;
                            end
                        end else begin
                            r_bitcnt <= w_pat_first ? 6'd1 : 6'd0;
                        end
                    end
                    ST_XFER: begin
                        if (w_dir_clash) begin
                            r_state  <= ST_MATCH;
                            r_bitcnt <= 6'd0;
                            r_dir    <= DIR_NONE;
                        end else begin
                            r_dir   <= w_dir_now;
                            r_shift <= bus.A2 ? (r_shift >> 1) : w_shift_wr;
                            if (w_last) begin
                                r_state  <= ST_MATCH;
                                r_bitcnt <= 6'd0;
                                r_dir    <= DIR_NONE;
                                if (!bus.A2)
                                    r_time <= w_commit;
                            end else begin
                                r_bitcnt <= r_bitcnt + 6'd1;
                            end
                        end
                    end
                    default: r_state <= ST_MATCH;
                endcase
            end
        end
    end

    assign bus.RAMROMCSgb = bus.RAMROMCS & (r_state != ST_XFER);
    assign bus.CLKDOE     = (r_state == ST_XFER) & bus.RAMROMCS & bus.A2 & (r_dir != DIR_WR);
    assign bus.CLKD0      = r_shift[0];
    assign bus.XFER       = (r_state == ST_XFER);

endmodule

// File: tb/tb_phantom_clock_gate.sv
// Randomized bench for phantom_clock_gate against a decimal-arithmetic time model and scripted unlock sequences.
module tb_phantom_clock_gate;

    localparam logic [63:0] PATTERN    = 64'h5CA3_3AC5_5CA3_3AC5;
    localparam logic [63:0] RESET_TIME = 64'h0001_0101_0000_0000;
`ifdef CENTI_EN
    localparam logic [7:0]  CC_TOP     = 8'h99;
`else
    localparam logic [7:0]  CC_TOP     = 8'h00;
`endif

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    phantom_clock_gate_if bus ();

    phantom_clock_gate dut (
        .i_c7m (clk),
        .i_res (res),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model_time;
    logic        s_d0, s_doe, s_gb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: fields as decimal integers ----------------
    function automatic int dec(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [63:0] model_tick(input logic [63:0] t);
        logic [63:0] r;
        bit          c;
        int          f;
        r = t;
`ifdef CENTI_EN
        f = dec(t[7:0]);
        if (f >= 99) begin r[7:0] = 8'h00; c = 1; end
        else begin r[7:0] = bcd(f + 1); c = 0; end
`else
        c = 1;
`endif
        if (c) begin
            f = dec(t[15:8]);
            if (f >= 59) begin r[15:8] = 8'h00; c = 1; end
            else begin r[15:8] = bcd(f + 1); c = 0; end
        end
        if (c) begin
            f = dec(t[23:16]);
            if (f >= 59) begin r[23:16] = 8'h00; c = 1; end
            else begin r[23:16] = bcd(f + 1); c = 0; end
        end
        if (c) begin
            f = dec(t[31:24]);
            if (f >= 23) begin r[31:24] = 8'h00; c = 1; end
            else begin r[31:24] = bcd(f + 1); c = 0; end
        end
        if (c) begin
            f = dec(t[39:32]);
            r[39:32] = (f >= 7) ? 8'h01 : bcd(f + 1);
        end
        return r;
    endfunction

    function automatic logic [63:0] model_commit(input logic [63:0] v);
`ifdef CENTI_EN
        return v;
`else
        return {v[63:8], 8'h00};
`endif
    endfunction

    function automatic logic [63:0] rand_time();
        int   ss, mm, hh, dy, dt, mo, yr;
        logic [7:0] cc;
        ss = ($urandom_range(0, 1) == 1) ? int'($urandom_range(55, 59)) : int'($urandom_range(0, 59));
        mm = ($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 59));
        hh = ($urandom_range(0, 1) == 1) ? 23 : int'($urandom_range(0, 23));
        dy = int'($urandom_range(1, 7));
        dt = int'($urandom_range(1, 31));
        mo = int'($urandom_range(1, 12));
        yr = int'($urandom_range(0, 99));
`ifdef CENTI_EN
        cc = bcd(($urandom_range(0, 1) == 1) ? int'($urandom_range(95, 99)) : int'($urandom_range(0, 99)));
`else
        cc = 8'($urandom);
`endif
        return {bcd(yr), bcd(mo), bcd(dt), bcd(dy), bcd(hh), bcd(mm), bcd(ss), cc};
    endfunction

    // ---------------- bus tasks ----------------
    task automatic access(input logic cs, input logic a2, input logic a0, input logic tk);
        if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            bus.ACC_STB  = 1'b1;
            bus.RAMROMCS = 1'b0;
            bus.A2       = 1'($urandom_range(0, 1));
            bus.A0       = 1'($urandom_range(0, 1));
            @(negedge clk);
            bus.ACC_STB  = 1'b0;
        end
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        bus.ACC_STB  = 1'b1;
        bus.RAMROMCS = cs;
        bus.A2       = a2;
        bus.A0       = a0;
        bus.TICK     = tk;
        #1;
        s_d0  = bus.CLKD0;
        s_doe = bus.CLKDOE;
        s_gb  = bus.RAMROMCSgb;
        @(negedge clk);
        bus.ACC_STB  = 1'b0;
        bus.RAMROMCS = 1'b0;
        bus.TICK     = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        bus.TICK = 1'b1;
        @(negedge clk);
        bus.TICK = 1'b0;
        model_time = model_tick(model_time);
    endtask

    task automatic clear_match();
        access(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input int lo, input int hi, input logic [63:0] v);
        for (int i = lo; i <= hi; i++)
            access(1'b1, 1'b0, v[i], 1'b0);
    endtask

    task automatic unlock();
        clear_match();
        send_bits(0, 63, PATTERN);
        check("unlock_xfer", 64'(bus.XFER), 64'd1);
    endtask

    task automatic finish_read(input string tag, input logic [63:0] exp, input int tick_at,
                               output logic [63:0] got);
        int bad_doe, bad_gb;
        bad_doe = 0;
        bad_gb  = 0;
        for (int i = 0; i < 64; i++) begin
            if (i == tick_at) pulse_tick();
            access(1'b1, 1'b1, 1'b0, 1'b0);
            got[i] = s_d0;
            if (s_doe !== 1'b1) bad_doe++;
            if (s_gb !== 1'b0) bad_gb++;
        end
        check(tag, got, exp);
        check({tag, "_doe_misses"}, 64'(bad_doe), 64'd0);
        check({tag, "_gb_leaks"}, 64'(bad_gb), 64'd0);
        check({tag, "_xfer_end"}, 64'(bus.XFER), 64'd0);
    endtask

    task automatic check_time(input string tag, input int tick_at, output logic [63:0] got);
        logic [63:0] exp;
        exp = model_time;
        unlock();
        finish_read(tag, exp, tick_at, got);
    endtask

    task automatic write_time(input logic [63:0] v, input logic tk_last);
        unlock();
        for (int i = 0; i < 64; i++)
            access(1'b1, 1'b0, v[i], (i == 63) ? tk_last : 1'b0);
        model_time = model_commit(v);
        check("write_xfer_end", 64'(bus.XFER), 64'd0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [63:0] got;
        logic        wb;
        int          k;

        bus.ACC_STB  = 1'b0;
        bus.RAMROMCS = 1'b0;
        bus.A0       = 1'b0;
        bus.A2       = 1'b0;
        bus.TICK     = 1'b0;
        res          = 1'b1;
        repeat (3) @(negedge clk);
        bus.RAMROMCS = 1'b1;
        bus.A2       = 1'b1;
        #1;
        check("rst_gb",   64'(bus.RAMROMCSgb), 64'd1);
        check("rst_doe",  64'(bus.CLKDOE),     64'd0);
        check("rst_d0",   64'(bus.CLKD0),      64'd0);
        check("rst_xfer", 64'(bus.XFER),       64'd0);
        @(negedge clk);
        res          = 1'b0;
        bus.RAMROMCS = 1'b0;
        bus.A2       = 1'b0;
        model_time   = RESET_TIME;

        check_time("reset_time", -1, got);
        check("reset_time_const", got, 64'h0001_0101_0000_0000);

        write_time(64'h2412_3105_1345_3000, 1'b0);
        check_time("write_readback", -1, got);
        pulse_tick();
        check_time("write_tick", -1, got);

        // Broken pattern: the wrong bit is re-evaluated as bit 0 of a fresh attempt.
        for (int n = 0; n < 4; n++) begin
            k = (n == 0) ? 20 : int'($urandom_range(1, 62));
            wb = ~PATTERN[k];
            clear_match();
            send_bits(0, k - 1, PATTERN);
            access(1'b1, 1'b0, wb, 1'b0);
            if (wb == PATTERN[0]) begin
                send_bits(1, 62, PATTERN);
            end else begin
                send_bits(0, 62, PATTERN);
            end
            check("break_no_early_unlock", 64'(bus.XFER), 64'd0);
            send_bits(63, 63, PATTERN);
            check("break_unlock", 64'(bus.XFER), 64'd1);
            finish_read("break_read", model_time, -1, got);
        end

        clear_match();
        send_bits(0, 29, PATTERN);
        access(1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(30, 63, PATTERN);
        check("midread_resets", 64'(bus.XFER), 64'd0);

        clear_match();
        send_bits(0, 29, PATTERN);
        access(1'b0, 1'b1, ~PATTERN[30], 1'b0);
        send_bits(30, 63, PATTERN);
        check("unqualified_ignored", 64'(bus.XFER), 64'd1);
        finish_read("unqualified_read", model_time, -1, got);

        write_time({8'h24, 8'h12, 8'h31, 8'h07, 8'h23, 8'h59, 8'h59, CC_TOP}, 1'b0);
        pulse_tick();
        check_time("rollover", -1, got);
        check("rollover_const", got, 64'h2412_3101_0000_0000);

        write_time({8'h24, 8'h12, 8'h31, 8'h03, 8'h10, 8'h10, 8'h75, CC_TOP}, 1'b0);
        pulse_tick();
        check_time("illegal_ss", -1, got);

        write_time(rand_time(), 1'b1);
        check_time("commit_beats_tick", -1, got);

        check_time("tick_during_read", 17, got);
        check_time("after_read_tick", -1, got);

        unlock();
        send_bits(0, 9, 64'($urandom));
        access(1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_xfer", 64'(bus.XFER), 64'd0);
        access(1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_gb_passes", 64'(s_gb), 64'd1);
        check("abort_doe_off", 64'(s_doe), 64'd0);
        check_time("abort_time", -1, got);

        write_time(rand_time(), 1'b0);
        unlock();
        send_bits(0, 39, {$urandom, $urandom});
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        model_time = RESET_TIME;
        check("res_xfer", 64'(bus.XFER), 64'd0);
        check_time("res_time", -1, got);

        for (int n = 0; n < 6; n++) begin
            write_time(rand_time(), 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 4)) pulse_tick();
            check_time("random_time", ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : -1, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
